uart_receiver: RTL and testbench

UART serial receiver, the receive-side counterpart of the team's UART transmitter.
- Samples the asynchronous serial line and recovers frames: start bit, DATA_BITS data bits LSB first, optional even/odd parity bit, one stop bit.
- Delivers each byte as a parallel word with a one-cycle valid strobe and per-frame error flags.
- Sits between the board Rx pin and the consuming logic, in the same clock domain as the transmitter.

---
 rtl/uart_receiver.sv | 181 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, per-frame error flags.
// Optional parity bit is compiled in with `define UART_RX_PARITY_EN.
module uart_receiver #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 Clock_In,
  input  logic                 Reset,
  input  logic                 Rx_dataIn,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Data_Valid,
  output logic                 Parity_Error,
  output logic                 Framing_Error,
  output logic                 Busy
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int TW  = $clog2(CPB);
  localparam int IW  = $clog2(DATA_BITS);

  localparam logic [TW-1:0] T_FULL = TW'(CPB - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CPB / 2 - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

  if (CPB < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_receiver: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_m, rx_s;
  logic [TW-1:0]        timer_q, timer_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 full_bit;

`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  logic perr_out_q, perr_out_d;
`endif

  always_ff @(posedge Clock_In) begin
    if (!Reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= Rx_dataIn;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge Clock_In) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
      perr_out_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q     <= perr_d;
      perr_out_q <= perr_out_d;
`endif
    end
  end

  assign full_bit = (timer_q == T_FULL);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + TW'(1);
    idx_d      = idx_q;
    shift_d    = shift_q;
    dout_d     = dout_q;
    valid_d    = 1'b0;
    ferr_d     = ferr_q;
`ifdef UART_RX_PARITY_EN
    perr_d     = perr_q;
    perr_out_d = perr_out_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (timer_q == T_HALF) begin
          timer_d = '0;
          idx_d   = '0;
`ifdef UART_RX_PARITY_EN
          perr_d  = 1'b0;
`endif
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (full_bit) begin
          timer_d = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == I_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (full_bit) begin
          timer_d = '0;
          perr_d  = rx_s ^ (^shift_q) ^ PARITY_ODD[0];
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (full_bit) begin
          timer_d    = '0;
          dout_d     = shift_q;
          valid_d    = 1'b1;
          ferr_d     = !rx_s;
`ifdef UART_RX_PARITY_EN
          perr_out_d = perr_q;
`endif
          // A low stop bit is treated as a line break until rx returns high
          state_d    = rx_s ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        timer_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign Data_Out      = dout_q;
  assign Data_Valid    = valid_q;
  assign Framing_Error = ferr_q;
  assign Busy          = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign Parity_Error  = perr_out_q;
`else
  assign Parity_Error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: vector table plus scoreboard of expected frames.
// Frame format follows whether UART_RX_PARITY_EN is defined.
module tb_uart_receiver;

  localparam int CLKF = 1600000;
  localparam int BR   = 100000;
  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam logic PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAT = 2 + CPB / 2 + (DB + 1 + PB) * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          parity_error;
  logic          framing_error;
  logic          busy;

  always #5 clk = ~clk;

  uart_receiver #(
    .CLK_FREQ  (CLKF),
    .BAUD      (BR),
    .DATA_BITS (DB),
    .PARITY_ODD(0)
  ) dut (
    .Clock_In     (clk),
    .Reset        (rst_n),
    .Rx_dataIn    (rx),
    .Data_Out     (data_out),
    .Data_Valid   (data_valid),
    .Parity_Error (parity_error),
    .Framing_Error(framing_error),
    .Busy         (busy)
  );

  typedef struct {
    logic [7:0] data;
    bit         perr;
    bit         ferr;
    int         t0;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    bit         pbad;
    bit         stopb;
    int         hold;
    int         gap;
  } vec_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   valid_cnt = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && data_valid) begin
      valid_cnt++;
      if (prev_valid) begin
        bad++;
        $display("FAIL valid_twice got=1 want=0");
      end
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid got=%0h want=none", data_out);
      end else begin
        e = q.pop_front();
        chk("data", 32'(data_out), 32'(e.data));
        chk("parity_err", 32'(parity_error), 32'(e.perr));
        chk("framing_err", 32'(framing_error), 32'(e.ferr));
        total++;
        if (cyc - e.t0 < LAT - 1 || cyc - e.t0 > LAT + 1) begin
          bad++;
          $display("FAIL latency got=%0d want=%0d", cyc - e.t0, LAT);
        end
      end
    end
    prev_valid = data_valid;
  end

  task automatic bit_out(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v);
    exp_t x;
    logic par;
    x.data = v.data;
    x.perr = (PB == 1) ? v.pbad : 1'b0;
    x.ferr = !v.stopb;
    x.t0   = cyc;
    q.push_back(x);
    bit_out(1'b0);
    for (int i = 0; i < DB; i++) bit_out(v.data[i]);
    if (PB == 1) begin
      par = (^v.data) ^ PODD ^ v.pbad;
      bit_out(par);
    end
    bit_out(v.stopb);
    if (v.hold > 0) begin
      rx = 1'b0;
      repeat (v.hold) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() > 0; i++) @(posedge clk);
    #1;
    total++;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain_timeout got=%0d want=0", q.size());
      q.delete();
    end
  endtask

  vec_t vecs[9];
  int   v0;

  initial begin
    vecs[0] = '{8'hC4, 1'b0, 1'b1, 0, 20};
    vecs[1] = '{8'h23, 1'b1, 1'b1, 0, 20};
    vecs[2] = '{8'hC5, 1'b0, 1'b0, 64, 20};
    vecs[3] = '{8'hC6, 1'b0, 1'b1, 0, 20};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 0, 20};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 0, 20};
    vecs[6] = '{8'hA5, 1'b0, 1'b1, 0, 0};
    vecs[7] = '{8'h5A, 1'b0, 1'b1, 0, 0};
    vecs[8] = '{8'h3C, 1'b0, 1'b1, 0, 20};

    rst_n = 1'b0;
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_perr", 32'(parity_error), 32'h0);
    chk("rst_ferr", 32'(framing_error), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    v0 = valid_cnt;
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("idle_no_valid", 32'(valid_cnt), 32'(v0));
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_data", 32'(data_out), 32'h0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      send(vecs[i]);
      if (vecs[i].gap > 0) begin
        drain();
        repeat (vecs[i].gap) @(posedge clk);
        #1;
      end
    end
    drain();

    v0 = valid_cnt;
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("glitch_no_valid", 32'(valid_cnt), 32'(v0));
    chk("glitch_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    send('{8'hC7, 1'b0, 1'b1, 0, 0});
    drain();

    @(posedge clk);
    #1;
    bit_out(1'b0);
    bit_out(1'b0);
    bit_out(1'b0);
    bit_out(1'b0);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    rx = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_data", 32'(data_out), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    v0 = valid_cnt;
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_no_valid", 32'(valid_cnt), 32'(v0));
    @(posedge clk);
    #1;
    send('{8'hC9, 1'b0, 1'b1, 0, 0});
    drain();
    @(negedge clk);
    chk("final_data", 32'(data_out), 32'hC9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
